// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks IF branch predictions through ID/EX, checks them
// against the EX outcome and registers the MEM redirect/update strobe.
// Ports:
//   clk, rst (sync, active-high), hold (pipeline stall)
//   if_*           fetched slot and its prediction (valid, is_branch, pc, pred_taken, hit, pred_target)
//   ex_taken/ex_target  actual outcome for the instruction tracked in EX
//   PCSrc/mem_pc/t_addr/mem_is_taken  MEM-stage predictor update strobe
//   miss_predict/flush/redirect_pc    mispredict recovery
//   br_count/miss_count               wrapping perf counters
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             if_valid,
    input  logic             if_is_branch,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic             if_hit,
    input  logic [31:0]      if_pred_target,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             PCSrc,
    output logic [31:0]      mem_pc,
    output logic [31:0]      t_addr,
    output logic             mem_is_taken,
    output logic             miss_predict,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef struct packed {
        logic        valid;
        logic        is_branch;
        logic [31:0] pc;
        logic        pred_taken;
        logic        hit;
        logic [31:0] pred_target;
    } trk_t;

    typedef enum logic {
        RUN,
        SQUASH
    } state_t;

    state_t      state;
    state_t      state_nx;
    trk_t        if_slot;
    trk_t        id_q;
    trk_t        ex_q;
    logic        advance;
    logic        kill;
    logic        resolve;
    logic        mis;
    logic [31:0] pc_plus4;
    logic [31:0] pred_next;
    logic [31:0] act_next;

    assign if_slot = '{
        valid:       if_valid,
        is_branch:   if_is_branch,
        pc:          if_pc,
        pred_taken:  if_pred_taken,
        hit:         if_hit,
        pred_target: if_pred_target
    };

    // A wrong BTB target or a missing BTB entry both show up as a next-PC
    // difference, so one compare covers every kind of mispredict.
    always_comb begin
        pc_plus4  = ex_q.pc + 32'd4;
        pred_next = (ex_q.pred_taken & ex_q.hit) ? ex_q.pred_target
                                                 : pc_plus4;
        act_next  = ex_taken ? ex_target : pc_plus4;
        mis       = (pred_next != act_next);
        resolve   = (state == RUN) & ex_q.valid & ex_q.is_branch & ~hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // SQUASH lasts one cycle (the cycle flush is high); it drops the
    // wrong-path slot still sitting in IF and then returns unconditionally.
    always_comb begin
        state_nx = state;
        advance  = 1'b0;
        kill     = 1'b0;
        unique case (state)
            RUN: begin
                if (resolve & mis) begin
                    state_nx = SQUASH;
                    kill     = 1'b1;
                end else if (!hold) begin
                    advance = 1'b1;
                end
            end
            SQUASH: begin
                state_nx = RUN;
                kill     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (kill) begin
            id_q.valid <= 1'b0;
            ex_q.valid <= 1'b0;
        end else if (advance) begin
            id_q <= if_slot;
            ex_q <= id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PCSrc        <= 1'b0;
            miss_predict <= 1'b0;
            flush        <= 1'b0;
            mem_pc       <= '0;
            t_addr       <= '0;
            mem_is_taken <= 1'b0;
            redirect_pc  <= '0;
            br_count     <= '0;
            miss_count   <= '0;
        end else begin
            PCSrc        <= resolve;
            miss_predict <= resolve & mis;
            flush        <= resolve & mis;
            br_count     <= br_count + CNT_W'(resolve);
            miss_count   <= miss_count + CNT_W'(resolve & mis);
            if (resolve) begin
                mem_pc       <= ex_q.pc;
                t_addr       <= ex_target;
                mem_is_taken <= ex_taken;
                redirect_pc  <= act_next;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an in-flight queue model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        if_valid;
    logic        if_is_branch;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        if_hit;
    logic [31:0] if_pred_target;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        PCSrc;
    logic [31:0] mem_pc;
    logic [31:0] t_addr;
    logic        mem_is_taken;
    logic        miss_predict;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    branch_resolve_unit #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .hold          (hold),
        .if_valid      (if_valid),
        .if_is_branch  (if_is_branch),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .if_hit        (if_hit),
        .if_pred_target(if_pred_target),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .PCSrc         (PCSrc),
        .mem_pc        (mem_pc),
        .t_addr        (t_addr),
        .mem_is_taken  (mem_is_taken),
        .miss_predict  (miss_predict),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: instructions admitted from IF are pushed into a queue; the one
    // that has been in flight two edges is the EX instruction. A mispredict
    // empties the queue and the next edge admits nothing.
    typedef struct {
        bit        v;
        bit        br;
        bit [31:0] pc;
        bit        pt;
        bit        hit;
        bit [31:0] tgt;
    } rec_t;

    rec_t      inflight[$];
    rec_t      m_r;
    rec_t      m_f;
    bit        m_sq = 0;
    bit [31:0] m_pn;
    bit [31:0] m_an;
    bit        e_pcsrc = 0;
    bit        e_miss = 0;
    bit        e_taken = 0;
    bit [31:0] e_mem_pc = 0;
    bit [31:0] e_t_addr = 0;
    bit [31:0] e_redir = 0;
    bit [31:0] e_br = 0;
    bit [31:0] e_mc = 0;

    always @(posedge clk) begin
        if (rst) begin
            inflight.delete();
            m_sq     = 0;
            e_pcsrc  = 0;
            e_miss   = 0;
            e_taken  = 0;
            e_mem_pc = 0;
            e_t_addr = 0;
            e_redir  = 0;
            e_br     = 0;
            e_mc     = 0;
        end else begin
            e_pcsrc = 0;
            e_miss  = 0;
            if (m_sq) begin
                m_sq = 0;
            end else if (!hold) begin
                if (inflight.size() == 2 && inflight[1].v && inflight[1].br) begin
                    m_r  = inflight[1];
                    m_pn = (m_r.pt && m_r.hit) ? m_r.tgt : m_r.pc + 32'd4;
                    m_an = ex_taken ? ex_target : m_r.pc + 32'd4;
                    e_pcsrc  = 1;
                    e_mem_pc = m_r.pc;
                    e_t_addr = ex_target;
                    e_taken  = ex_taken;
                    e_redir  = m_an;
                    e_miss   = (m_pn != m_an);
                    e_br     = e_br + 1;
                    if (e_miss) e_mc = e_mc + 1;
                end
                if (e_miss) begin
                    inflight.delete();
                    m_sq = 1;
                end else begin
                    m_f.v   = if_valid;
                    m_f.br  = if_is_branch;
                    m_f.pc  = if_pc;
                    m_f.pt  = if_pred_taken;
                    m_f.hit = if_hit;
                    m_f.tgt = if_pred_target;
                    inflight.push_front(m_f);
                    if (inflight.size() > 2) void'(inflight.pop_back());
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("PCSrc", {31'd0, PCSrc}, {31'd0, e_pcsrc});
        chk("miss_predict", {31'd0, miss_predict}, {31'd0, e_miss});
        chk("flush", {31'd0, flush}, {31'd0, e_miss});
        chk("mem_is_taken", {31'd0, mem_is_taken}, {31'd0, e_taken});
        chk("mem_pc", mem_pc, e_mem_pc);
        chk("t_addr", t_addr, e_t_addr);
        chk("redirect_pc", redirect_pc, e_redir);
        chk("br_count", br_count, e_br);
        chk("miss_count", miss_count, e_mc);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_if(input bit v, input bit br, input bit [31:0] pc,
                            input bit pt, input bit hit, input bit [31:0] tgt);
        if_valid       = v;
        if_is_branch   = br;
        if_pc          = pc;
        if_pred_taken  = pt;
        if_hit         = hit;
        if_pred_target = tgt;
    endtask

    task automatic drain();
        drive_if(0, 0, 0, 0, 0, 0);
        hold = 0;
        repeat (4) tick();
    endtask

    // Branch enters IF now, is in EX after two edges; the outcome is applied
    // then and the MEM strobe is visible after the third edge.
    task automatic run_branch(input bit [31:0] pc, input bit pt, input bit hit,
                              input bit [31:0] tgt, input bit tk,
                              input bit [31:0] atgt);
        drive_if(1, 1, pc, pt, hit, tgt);
        tick();
        drive_if(0, 0, 0, 0, 0, 0);
        tick();
        ex_taken  = tk;
        ex_target = atgt;
        tick();
    endtask

    initial begin
        rst = 1;
        hold = 0;
        ex_taken = 0;
        ex_target = 0;
        drive_if(1, 1, 32'h100, 1, 1, 32'h200);

        // reset held two edges with branches in IF
        tick();
        tick();
        chk("rst_pcsrc", {31'd0, PCSrc}, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        rst = 0;
        drive_if(0, 0, 0, 0, 0, 0);
        repeat (3) begin
            tick();
            chk("post_rst_pcsrc", {31'd0, PCSrc}, 32'd0);
        end

        // correct taken prediction
        run_branch(32'h100, 1, 1, 32'h200, 1, 32'h200);
        chk("t2_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("t2_miss", {31'd0, miss_predict}, 32'd0);
        chk("t2_flush", {31'd0, flush}, 32'd0);
        chk("t2_br_count", br_count, 32'd1);
        drain();

        // direction mispredict, wrong-path branches keep arriving in IF
        drive_if(1, 1, 32'h100, 0, 0, 32'h0);
        tick();
        drive_if(1, 1, 32'h104, 0, 0, 32'h0);
        tick();
        ex_taken  = 1;
        ex_target = 32'h80;
        tick();
        chk("t3_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_redirect", redirect_pc, 32'h80);
        chk("t3_t_addr", t_addr, 32'h80);
        chk("t3_miss_count", miss_count, 32'd1);
        repeat (3) begin
            tick();
            chk("t3_no_resolve", {31'd0, PCSrc}, 32'd0);
        end
        drain();

        // wrong BTB target, then not-taken with no BTB hit
        run_branch(32'h100, 1, 1, 32'h200, 1, 32'h240);
        chk("t4_flush", {31'd0, flush}, 32'd1);
        chk("t4_redirect", redirect_pc, 32'h240);
        drain();
        run_branch(32'h100, 1, 0, 32'h200, 0, 32'h200);
        chk("t4b_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("t4b_flush", {31'd0, flush}, 32'd0);
        chk("t4b_redirect", redirect_pc, 32'h104);
        drain();

        // stall while the branch sits in EX
        drive_if(1, 1, 32'h300, 0, 0, 32'h0);
        tick();
        drive_if(0, 0, 0, 0, 0, 0);
        tick();
        ex_taken  = 1;
        ex_target = 32'h400;
        hold = 1;
        repeat (3) begin
            tick();
            chk("t5_hold_pcsrc", {31'd0, PCSrc}, 32'd0);
        end
        hold = 0;
        tick();
        chk("t5_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("t5_mem_pc", mem_pc, 32'h300);
        chk("t5_t_addr", t_addr, 32'h400);
        tick();
        chk("t5_single", {31'd0, PCSrc}, 32'd0);
        drain();

        // reset on the mispredict edge, then wrap of pc+4
        drive_if(1, 1, 32'h100, 0, 0, 32'h0);
        tick();
        drive_if(0, 0, 0, 0, 0, 0);
        tick();
        ex_taken  = 1;
        ex_target = 32'h80;
        rst = 1;
        tick();
        rst = 0;
        chk("t6_flush", {31'd0, flush}, 32'd0);
        chk("t6_pcsrc", {31'd0, PCSrc}, 32'd0);
        chk("t6_miss_count", miss_count, 32'd0);
        run_branch(32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h1234);
        chk("t6_pcsrc2", {31'd0, PCSrc}, 32'd1);
        chk("t6_redirect", redirect_pc, 32'h0);
        chk("t6_flush2", {31'd0, flush}, 32'd0);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pcs[4];
            logic [31:0] tgs[4];
            pcs[0] = 32'h100; pcs[1] = 32'h2000; pcs[2] = 32'hFFFF_FFFC;
            pcs[3] = $urandom & 32'hFFFF_FFFC;
            tgs[0] = 32'h200; tgs[1] = 32'h240; tgs[2] = 32'h104;
            tgs[3] = $urandom;
            drive_if($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     pcs[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) != 0, tgs[$urandom_range(0, 3)]);
            ex_taken  = $urandom_range(0, 1) == 1;
            ex_target = tgs[$urandom_range(0, 3)];
            hold      = $urandom_range(0, 4) == 0;
            rst       = $urandom_range(0, 99) == 0;
            tick();
        end
        rst = 0;
        hold = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
